// File: rtl/reg_access_pkg.sv
// reg_access_pkg
//   Shared types and constants for the register-access sequencer slice.
//   seq_state_t : sequencer FSM states (IDLE, WAIT, READ, HOLD)
//   AREG_W_DEF  : default register address width
//   DATA_W_DEF  : default operand / writeback data width
//   REG_ZERO    : index of the hard-wired zero register
package reg_access_pkg;

    localparam int unsigned AREG_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_ZERO   = 0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READ,
        HOLD
    } seq_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Per-register pending bits plus a count of in-flight register-writing
//   instructions, with a RAW hazard check for two source addresses.
//   Optional feature macro: REG_ACCESS_EARLY_RELEASE_EN
//     defined   : hazard ignores a pending bit being cleared in the same cycle
//     undefined : hazard looks at the registered pending bits only
// Ports
//   clk, rst          clock, synchronous active-high reset
//   set_en, set_addr  mark a register pending (ignored for the zero register)
//   clr_en, clr_addr  writeback clears a register (ignored for the zero register)
//   chk_rs, chk_rt    source addresses to check
//   hazard            a non-zero source is pending
//   count             in-flight register-writing instructions
module reg_scoreboard
    import reg_access_pkg::*;
#(
    parameter int unsigned AREG_W          = AREG_W_DEF,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [AREG_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [AREG_W-1:0] clr_addr,
    input  logic [AREG_W-1:0] chk_rs,
    input  logic [AREG_W-1:0] chk_rt,
    output logic              hazard,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned       NREG = 1 << AREG_W;
    localparam logic [AREG_W-1:0] ZERO = AREG_W'(REG_ZERO);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] eff_pending;
    logic            set_hit;
    logic            clr_hit;

    assign set_hit = set_en && (set_addr != ZERO);
    // A writeback to a register that is not pending changes nothing.
    assign clr_hit = clr_en && (clr_addr != ZERO) && pending[clr_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            count   <= '0;
        end else begin
            if (clr_hit) pending[clr_addr] <= 1'b0;
            // Set is applied last so it wins over a same-register clear.
            if (set_hit) pending[set_addr] <= 1'b1;
            case ({set_hit, clr_hit})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef REG_ACCESS_EARLY_RELEASE_EN
    // The RF commits this writeback at the end of the cycle, so a READ
    // scheduled for the next cycle already observes the new value.
    always_comb begin
        eff_pending = pending;
        if (clr_en && (clr_addr != ZERO)) eff_pending[clr_addr] = 1'b0;
    end
`else
    assign eff_pending = pending;
`endif

    assign hazard = ((chk_rs != ZERO) && eff_pending[chk_rs]) ||
                    ((chk_rt != ZERO) && eff_pending[chk_rt]);

endmodule

// File: rtl/reg_access_seq.sv
// reg_access_seq
//   Operand-fetch and writeback sequencer on the initiator side of the
//   register-file port. Accepts decoded rs/rt/rd, stalls on RAW hazards
//   against in-flight writes, reads the RF, presents operands to execute,
//   and commits writeback results to the RF write port.
//   Optional feature macro: REG_ACCESS_EARLY_RELEASE_EN (see reg_scoreboard)
// Ports
//   clk, rst                              clock, synchronous active-high reset
//   dec_valid/dec_ready, dec_rs/rt/rd/wen decode handshake and fields
//   rf_rs/rf_rt, rf_rdata_a/rf_rdata_b    RF read addresses and data
//   ex_valid/ex_ready, ex_a/b/rd/wen      operands to execute
//   wb_valid/wb_ready, wb_rd/wb_data      writeback from execute
//   rf_we/rf_waddr/rf_wdata               RF write port
module reg_access_seq
    import reg_access_pkg::*;
#(
    parameter int unsigned DATA_W          = DATA_W_DEF,
    parameter int unsigned AREG_W          = AREG_W_DEF,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [AREG_W-1:0] dec_rs,
    input  logic [AREG_W-1:0] dec_rt,
    input  logic [AREG_W-1:0] dec_rd,
    input  logic              dec_wen,
    output logic [AREG_W-1:0] rf_rs,
    output logic [AREG_W-1:0] rf_rt,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [AREG_W-1:0] ex_rd,
    output logic              ex_wen,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [AREG_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              rf_we,
    output logic [AREG_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int unsigned       CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [AREG_W-1:0] ZERO  = AREG_W'(REG_ZERO);

    seq_state_t        state;
    logic [AREG_W-1:0] cap_rs;
    logic [AREG_W-1:0] cap_rt;
    logic [AREG_W-1:0] cap_rd;
    logic              cap_wen;
    logic              hazard;
    logic [CNT_W-1:0]  count;
    logic [AREG_W-1:0] chk_rs;
    logic [AREG_W-1:0] chk_rt;
    logic              ex_fire;

    // In IDLE the hazard is judged on the incoming fields so the accept
    // cycle already chooses between WAIT and READ.
    assign chk_rs = (state == IDLE) ? dec_rs : cap_rs;
    assign chk_rt = (state == IDLE) ? dec_rt : cap_rt;

    assign ex_fire = (state == HOLD) && ex_ready;

    reg_scoreboard #(
        .AREG_W          (AREG_W),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (ex_fire && ex_wen),
        .set_addr (ex_rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_rd),
        .chk_rs   (chk_rs),
        .chk_rt   (chk_rt),
        .hazard   (hazard),
        .count    (count)
    );

    assign dec_ready = (state == IDLE) && (count < CNT_W'(MAX_OUTSTANDING));
    assign ex_valid  = (state == HOLD);
    assign rf_rs     = cap_rs;
    assign rf_rt     = cap_rt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cap_rs  <= '0;
            cap_rt  <= '0;
            cap_rd  <= '0;
            cap_wen <= 1'b0;
            ex_a    <= '0;
            ex_b    <= '0;
            ex_rd   <= '0;
            ex_wen  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dec_valid && dec_ready) begin
                        cap_rs  <= dec_rs;
                        cap_rt  <= dec_rt;
                        cap_rd  <= dec_rd;
                        cap_wen <= dec_wen;
                        state   <= hazard ? WAIT : READ;
                    end
                end
                WAIT: begin
                    if (!hazard) state <= READ;
                end
                READ: begin
                    ex_a   <= (cap_rs == ZERO) ? '0 : rf_rdata_a;
                    ex_b   <= (cap_rt == ZERO) ? '0 : rf_rdata_b;
                    ex_rd  <= cap_rd;
                    ex_wen <= cap_wen;
                    state  <= HOLD;
                end
                HOLD: begin
                    if (ex_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wb_ready = 1'b1;
    assign rf_we    = wb_valid && (wb_rd != ZERO);
    assign rf_waddr = wb_rd;
    assign rf_wdata = wb_data;

endmodule

// File: tb/tb_reg_access_seq.sv
// tb_reg_access_seq
//   Directed bench for reg_access_seq with a behavioural register file.
//   Built with MAX_OUTSTANDING=2; REG_ACCESS_EARLY_RELEASE_EN selects the
//   expected RAW release latency.
module tb_reg_access_seq;

`ifdef REG_ACCESS_EARLY_RELEASE_EN
    localparam int REL_LAT = 1;
`else
    localparam int REL_LAT = 2;
`endif

    logic        clk;
    logic        rst;
    logic        dec_valid;
    logic        dec_ready;
    logic [4:0]  dec_rs;
    logic [4:0]  dec_rt;
    logic [4:0]  dec_rd;
    logic        dec_wen;
    logic [4:0]  rf_rs;
    logic [4:0]  rf_rt;
    logic [31:0] rf_rdata_a;
    logic [31:0] rf_rdata_b;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [4:0]  ex_rd;
    logic        ex_wen;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rf [32];

    reg_access_seq #(
        .DATA_W          (32),
        .AREG_W          (5),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_rs     (dec_rs),
        .dec_rt     (dec_rt),
        .dec_rd     (dec_rd),
        .dec_wen    (dec_wen),
        .rf_rs      (rf_rs),
        .rf_rt      (rf_rt),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .ex_rd      (ex_rd),
        .ex_wen     (ex_wen),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: r0 reads back all-ones so operand zeroing is visible.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'(i) * 32'h11;
            rf[0] <= 32'hFFFF_FFFF;
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end
    assign rf_rdata_a = rf[rf_rs];
    assign rf_rdata_b = rf[rf_rt];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one instruction and returns one cycle after the handshake edge.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic wen);
        int n;
        n = 0;
        dec_valid = 1'b1;
        dec_rs = rs;
        dec_rt = rt;
        dec_rd = rd;
        dec_wen = wen;
        while (!dec_ready && n < 50) begin
            tick();
            n++;
        end
        check("issue_ready", 32'(dec_ready), 32'd1);
        tick();
        dec_valid = 1'b0;
    endtask

    task automatic wb_pulse(input logic [4:0] rd, input logic [31:0] data);
        wb_valid = 1'b1;
        wb_rd = rd;
        wb_data = data;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic ex_accept();
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        dec_valid = 1'b0;
        dec_rs = '0;
        dec_rt = '0;
        dec_rd = '0;
        dec_wen = 1'b0;
        ex_ready = 1'b0;
        wb_valid = 1'b0;
        wb_rd = '0;
        wb_data = '0;

        // Reset
        tick();
        tick();
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_dec_ready", 32'(dec_ready), 32'd1);
        check("rst_count", 32'(dut.u_sb.count), 32'd0);
        check("rst_pending", dut.u_sb.pending, 32'd0);
        check("rst_ex_a", ex_a, 32'd0);
        check("rst_rf_rs", 32'(rf_rs), 32'd0);
        rst = 1'b0;
        tick();

        // No hazard, then 3 cycles of backpressure
        issue(5'd1, 5'd2, 5'd3, 1'b1);
        check("nh_read_ex_valid", 32'(ex_valid), 32'd0);
        check("nh_rf_rs", 32'(rf_rs), 32'd1);
        check("nh_rf_rt", 32'(rf_rt), 32'd2);
        tick();
        check("nh_ex_valid", 32'(ex_valid), 32'd1);
        check("nh_ex_a", ex_a, 32'h11);
        check("nh_ex_b", ex_b, 32'h22);
        check("nh_ex_rd", 32'(ex_rd), 32'd3);
        check("nh_ex_wen", 32'(ex_wen), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_ex_valid", 32'(ex_valid), 32'd1);
            check("bp_ex_a", ex_a, 32'h11);
            check("bp_ex_b", ex_b, 32'h22);
            check("bp_ex_rd", 32'(ex_rd), 32'd3);
            check("bp_dec_ready", 32'(dec_ready), 32'd0);
            check("bp_pending", dut.u_sb.pending, 32'd0);
        end
        ex_accept();
        check("nh_done_ex_valid", 32'(ex_valid), 32'd0);
        check("nh_pending", dut.u_sb.pending, 32'h0000_0008);
        check("nh_count", 32'(dut.u_sb.count), 32'd1);
        wb_valid = 1'b1;
        wb_rd = 5'd3;
        wb_data = 32'h33;
        #1;
        check("wb_rf_we", 32'(rf_we), 32'd1);
        check("wb_rf_waddr", 32'(rf_waddr), 32'd3);
        check("wb_rf_wdata", rf_wdata, 32'h33);
        check("wb_ready", 32'(wb_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        check("wb_pending", dut.u_sb.pending, 32'd0);
        check("wb_count", 32'(dut.u_sb.count), 32'd0);

        // RAW hazard on r5, released by writeback of 0xAB
        issue(5'd4, 5'd4, 5'd5, 1'b1);
        tick();
        ex_accept();
        check("raw_pending", dut.u_sb.pending, 32'h0000_0020);
        issue(5'd5, 5'd0, 5'd6, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("raw_wait_ex_valid", 32'(ex_valid), 32'd0);
            check("raw_wait_dec_ready", 32'(dec_ready), 32'd0);
            tick();
        end
        wb_pulse(5'd5, 32'hAB);
        for (int i = 0; i < REL_LAT; i++) begin
            check("raw_release_early", 32'(ex_valid), 32'd0);
            tick();
        end
        check("raw_ex_valid", 32'(ex_valid), 32'd1);
        check("raw_ex_a", ex_a, 32'hAB);
        check("r0_ex_b", ex_b, 32'd0);
        ex_accept();
        check("raw_done_pending", dut.u_sb.pending, 32'h0000_0040);
        check("raw_done_count", 32'(dut.u_sb.count), 32'd1);

        // Writeback to r0 and to a non-pending register
        wb_valid = 1'b1;
        wb_rd = 5'd0;
        wb_data = 32'h99;
        #1;
        check("r0_rf_we", 32'(rf_we), 32'd0);
        tick();
        wb_valid = 1'b0;
        check("r0_pending", dut.u_sb.pending, 32'h0000_0040);
        check("r0_count", 32'(dut.u_sb.count), 32'd1);
        wb_pulse(5'd7, 32'h77);
        check("np_pending", dut.u_sb.pending, 32'h0000_0040);
        check("np_count", 32'(dut.u_sb.count), 32'd1);

        // Full at MAX_OUTSTANDING=2
        issue(5'd0, 5'd0, 5'd8, 1'b1);
        tick();
        ex_accept();
        check("full_count", 32'(dut.u_sb.count), 32'd2);
        check("full_dec_ready", 32'(dec_ready), 32'd0);
        tick();
        check("full_dec_ready_hold", 32'(dec_ready), 32'd0);
        wb_valid = 1'b1;
        wb_rd = 5'd6;
        wb_data = 32'h66;
        #1;
        check("full_wb_cycle_dec_ready", 32'(dec_ready), 32'd0);
        tick();
        wb_valid = 1'b0;
        check("full_release_dec_ready", 32'(dec_ready), 32'd1);
        check("full_release_count", 32'(dut.u_sb.count), 32'd1);

        // Same-cycle set and clear of r8: set wins, count nets zero
        issue(5'd0, 5'd0, 5'd8, 1'b1);
        tick();
        ex_ready = 1'b1;
        wb_valid = 1'b1;
        wb_rd = 5'd8;
        wb_data = 32'h88;
        tick();
        ex_ready = 1'b0;
        wb_valid = 1'b0;
        check("sc_pending", dut.u_sb.pending, 32'h0000_0100);
        check("sc_count", 32'(dut.u_sb.count), 32'd1);
        wb_pulse(5'd8, 32'h89);
        check("sc_clear_pending", dut.u_sb.pending, 32'd0);
        check("sc_clear_count", 32'(dut.u_sb.count), 32'd0);

        // Reset while holding operands drops the instruction
        issue(5'd1, 5'd2, 5'd9, 1'b1);
        tick();
        check("mr_ex_valid_before", 32'(ex_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("mr_ex_valid", 32'(ex_valid), 32'd0);
        check("mr_ex_a", ex_a, 32'd0);
        check("mr_dec_ready", 32'(dec_ready), 32'd1);
        rst = 1'b0;
        ex_accept();
        check("mr_pending", dut.u_sb.pending, 32'd0);
        check("mr_count", 32'(dut.u_sb.count), 32'd0);
        check("mr_no_replay", 32'(ex_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
